dma_pcie_c2h_axis_arb: RTL

Parametrised N-channel C2H AXI-Stream arbiter placed between user C2H packet sources and the single DMA C2H streaming port. It grants channels round-robin, one whole packet at a time, and registers the output through a full-throughput skid stage. It checks per-byte input parity and regenerates output parity. Data width, user-field width, channel count and parity checking are all generics.

---
 rtl/dma_pcie_c2h_axis_arb.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_pcie_c2h_axis_arb.sv
// N-channel C2H AXI-Stream arbiter: round-robin, one whole packet per grant, registered
// 2-entry skid output, per-byte input parity check and regenerated output parity.
module dma_pcie_c2h_axis_arb #(
  parameter int DATA_W    = 512,
  parameter int USR_W     = 64,
  parameter int NUM_CH    = 4,
  parameter bit PAR_CHECK = 1'b1,
  localparam int KW       = DATA_W / 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH*KW-1:0]     s_tparity,
  input  logic [NUM_CH*KW-1:0]     s_tkeep,
  input  logic [NUM_CH*USR_W-1:0]  s_tusr,
  input  logic [NUM_CH-1:0]        s_tlast,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KW-1:0]            m_tkeep,
  output logic [USR_W-1:0]         m_tusr,
  output logic                     m_tlast,
  output logic [KW-1:0]            m_tparity,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [CH_W-1:0]          m_tch,
  output logic [NUM_CH-1:0]        par_err,
  input  logic                     par_err_clr,
  output logic                     dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // a source holds valid and its payload stable until that edge, and ready never waits on valid.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   grant, grant_nxt, rr_last, rr_last_nxt;
  logic              sop, sop_nxt;
  logic              rdy_q;
  logic [1:0]        cnt, cnt_nxt;

  logic [DATA_W-1:0] in_data, sk_data;
  logic [KW-1:0]     in_keep, in_par, sk_keep;
  logic [USR_W-1:0]  in_usr, sk_usr;
  logic              in_last, in_valid, sk_last;
  logic [CH_W-1:0]   sk_ch;

  logic              acc, pop, in_perr;
  logic              load_head, load_skid, shift;
  logic              pick_found;
  logic [CH_W-1:0]   pick_idx, pick_base;
  logic [NUM_CH-1:0] err_set;
  int                best_d, d;

  assign dbg_state = (state == LOCKED);
  assign m_tvalid  = (cnt != 2'd0);

  always_comb begin
    in_data  = '0;
    in_keep  = '0;
    in_par   = '0;
    in_usr   = '0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == CH_W'(c)) begin
        in_data  = s_tdata[c*DATA_W +: DATA_W];
        in_keep  = s_tkeep[c*KW +: KW];
        in_par   = s_tparity[c*KW +: KW];
        in_usr   = s_tusr[c*USR_W +: USR_W];
        in_last  = s_tlast[c];
        in_valid = s_tvalid[c];
      end
    end
  end

  // s_tready depends only on registered state, grant and rdy_q.
  always_comb begin
    s_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state == LOCKED && rdy_q && grant == CH_W'(c)) s_tready[c] = 1'b1;
    end
  end

  assign acc = (state == LOCKED) && rdy_q && in_valid;
  assign pop = m_tvalid && m_tready;

  // Round-robin search: distance 0 is the channel just after pick_base.
  assign pick_base = (acc && in_last) ? grant : rr_last;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    best_d     = NUM_CH;
    d          = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      d = (j + NUM_CH - int'(pick_base) - 1) % NUM_CH;
      if (s_tvalid[j] && d < best_d) begin
        best_d     = d;
        pick_idx   = CH_W'(j);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    sop_nxt     = sop;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = LOCKED;
          grant_nxt = pick_idx;
          sop_nxt   = 1'b1;
        end
      end
      LOCKED: begin
        if (acc && in_last) begin
          rr_last_nxt = grant;
          if (pick_found) begin
            grant_nxt = pick_idx;
            sop_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (acc) begin
          sop_nxt = 1'b0;
        end else if (sop && !in_valid) begin
          // Re-granted channel had no next packet; nothing started, so move on.
          if (pick_found) grant_nxt = pick_idx;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state   <= IDLE;
      grant   <= '0;
      rr_last <= CH_W'(NUM_CH - 1);
      sop     <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;
      sop     <= sop_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (acc && !pop)      cnt_nxt = cnt + 2'd1;
    else if (!acc && pop) cnt_nxt = cnt - 2'd1;
  end

  assign load_head = acc && ((cnt == 2'd0) || (cnt == 2'd1 && pop));
  assign load_skid = acc && (cnt == 2'd1) && !pop;
  assign shift     = pop && (cnt == 2'd2);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt     <= 2'd0;
      rdy_q   <= 1'b1;
      m_tdata <= '0;
      m_tkeep <= '0;
      m_tusr  <= '0;
      m_tlast <= 1'b0;
      m_tch   <= '0;
      sk_data <= '0;
      sk_keep <= '0;
      sk_usr  <= '0;
      sk_last <= 1'b0;
      sk_ch   <= '0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != 2'd2);
      if (load_head) begin
        m_tdata <= in_data;
        m_tkeep <= in_keep;
        m_tusr  <= in_usr;
        m_tlast <= in_last;
        m_tch   <= grant;
      end else if (shift) begin
        m_tdata <= sk_data;
        m_tkeep <= sk_keep;
        m_tusr  <= sk_usr;
        m_tlast <= sk_last;
        m_tch   <= sk_ch;
      end
      if (load_skid) begin
        sk_data <= in_data;
        sk_keep <= in_keep;
        sk_usr  <= in_usr;
        sk_last <= in_last;
        sk_ch   <= grant;
      end
    end
  end

  always_comb begin
    in_perr = 1'b0;
    for (int b = 0; b < KW; b++) begin
      if (in_keep[b] && (in_par[b] != ^in_data[b*8 +: 8])) in_perr = 1'b1;
    end
  end

  always_comb begin
    err_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (PAR_CHECK && acc && in_perr && grant == CH_W'(c)) err_set[c] = 1'b1;
    end
  end

  // A new error in the clear cycle survives the clear.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) par_err <= '0;
    else              par_err <= (par_err & {NUM_CH{!par_err_clr}}) | err_set;
  end

  always_comb begin
    m_tparity = '0;
    for (int b = 0; b < KW; b++) m_tparity[b] = ^m_tdata[b*8 +: 8];
  end

endmodule
